// File: rtl/perceptron_pkg.sv
// Shared constants for the perceptron engine: APB address map, CTRL/STATUS
// bit positions and the controller state encoding.
package perceptron_pkg;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Register word addresses
  localparam int unsigned ADDR_CTRL   = 'h000;
  localparam int unsigned ADDR_STATUS = 'h001;
  localparam int unsigned ADDR_BIAS   = 'h002;
  localparam int unsigned ADDR_SCORE  = 'h003;
  localparam int unsigned PIXEL_BASE  = 'h400;
  localparam int unsigned WEIGHT_BASE = 'h800;

  // Low address bits that index a pixel/weight inside its region
  localparam int unsigned IDX_BITS = 10;

  // CTRL bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  // STATUS bits
  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;
  localparam int unsigned STAT_RESULT = 2;

endpackage

// File: rtl/pixel_weight_ram.sv
// Pixel and weight storage: two arrays sharing one write address and one
// combinational read address. Contents are deliberately not reset.
module pixel_weight_ram #(
  parameter int PIXEL_WIDTH  = 24,
  parameter int WEIGHT_WIDTH = 15,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clk,
  input  logic                    we_pixel,
  input  logic                    we_weight,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [PIXEL_WIDTH-1:0]  wdata_pixel,
  input  logic [WEIGHT_WIDTH-1:0] wdata_weight,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [PIXEL_WIDTH-1:0]  rd_pixel,
  output logic [WEIGHT_WIDTH-1:0] rd_weight
);

  logic [PIXEL_WIDTH-1:0]  pixel_mem  [DEPTH];
  logic [WEIGHT_WIDTH-1:0] weight_mem [DEPTH];

  // APB write port
  always_ff @(posedge clk) begin
    if (we_pixel)  pixel_mem[waddr]  <= wdata_pixel;
    if (we_weight) weight_mem[waddr] <= wdata_weight;
  end

  // Combinational read port
  always_comb begin
    rd_pixel  = pixel_mem[raddr];
    rd_weight = weight_mem[raddr];
  end

endmodule

// File: rtl/perceptron_engine.sv
// APB-controlled single-neuron perceptron: dot product of an image against a
// weight vector plus bias, with saturated score and binary classification.
module perceptron_engine
  import perceptron_pkg::*;
#(
  parameter int AMBA_WORD        = 24,
  parameter int AMBA_ADDR_DEPTH  = 12,
  parameter int WEIGHT_PRECISION = 5,
  parameter int CHANNELS         = 3,
  parameter int NUM_PIXELS       = 1024,
  parameter int ACC_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_DEPTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       CatRecOut,
  output logic                       done_irq
);

  localparam int CW   = AMBA_WORD / CHANNELS;
  localparam int WP   = WEIGHT_PRECISION;
  localparam int WW   = CHANNELS * WEIGHT_PRECISION;
  localparam int IDXW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int RGW  = AMBA_ADDR_DEPTH - IDX_BITS;
  localparam int SW   = ACC_WIDTH + 1;

  state_t state, state_nxt;

  logic                        busy;
  logic [IDXW-1:0]             idx;
  logic                        last;
  logic signed [ACC_WIDTH-1:0] acc, prod, dot;
  logic [AMBA_WORD-1:0]        bias, score, score_sat;
  logic signed [SW-1:0]        s, s_max, s_min;
  logic                        done, result;

  logic                 access, in_range, mapped, err, wr, rd;
  logic [RGW-1:0]       region;
  logic [IDX_BITS-1:0]  offs;
  logic                 sel_ctrl, sel_status, sel_bias, sel_score, sel_pix, sel_wt;
  logic                 start_ev, clear_ev;
  logic [AMBA_WORD-1:0] status;
  logic [IDXW-1:0]      raddr;
  logic [AMBA_WORD-1:0] rd_pixel;
  logic [WW-1:0]        rd_weight;

  assign PREADY    = 1'b1;
  assign CatRecOut = result;
  assign busy      = (state != S_IDLE);

  // APB address decode and access legality
  always_comb begin
    access     = PSEL & PENABLE;
    region     = PADDR[AMBA_ADDR_DEPTH-1:IDX_BITS];
    offs       = PADDR[IDX_BITS-1:0];
    in_range   = int'(offs) < NUM_PIXELS;
    sel_ctrl   = (PADDR == AMBA_ADDR_DEPTH'(ADDR_CTRL));
    sel_status = (PADDR == AMBA_ADDR_DEPTH'(ADDR_STATUS));
    sel_bias   = (PADDR == AMBA_ADDR_DEPTH'(ADDR_BIAS));
    sel_score  = (PADDR == AMBA_ADDR_DEPTH'(ADDR_SCORE));
    sel_pix    = (region == RGW'(PIXEL_BASE >> IDX_BITS)) && in_range;
    sel_wt     = (region == RGW'(WEIGHT_BASE >> IDX_BITS)) && in_range;
    mapped     = sel_ctrl | sel_status | sel_bias | sel_score | sel_pix | sel_wt;
    err        = ~mapped | (busy & (sel_pix | sel_wt)) | (busy & sel_bias & PWRITE);
    PSLVERR    = access & err;
    wr         = access & PWRITE & ~err;
    rd         = access & ~PWRITE & ~err;
    start_ev   = wr & sel_ctrl & PWDATA[CTRL_START] & (state == S_IDLE);
    clear_ev   = wr & sel_ctrl & PWDATA[CTRL_CLEAR] & ~PWDATA[CTRL_START] & (state == S_IDLE);
  end

  // Read data mux; zero whenever no legal read is in its access phase
  always_comb begin
    status              = '0;
    status[STAT_BUSY]   = busy;
    status[STAT_DONE]   = done;
    status[STAT_RESULT] = result;
    PRDATA              = '0;
    if (rd) begin
      if (sel_status)     PRDATA = status;
      else if (sel_bias)  PRDATA = bias;
      else if (sel_score) PRDATA = score;
      else if (sel_pix)   PRDATA = rd_pixel;
      else if (sel_wt)    PRDATA = AMBA_WORD'(rd_weight);
    end
  end

  assign raddr = busy ? idx : offs[IDXW-1:0];

  pixel_weight_ram #(
    .PIXEL_WIDTH  (AMBA_WORD),
    .WEIGHT_WIDTH (WW),
    .DEPTH        (NUM_PIXELS),
    .ADDR_WIDTH   (IDXW)
  ) u_ram (
    .clk          (clk),
    .we_pixel     (wr & sel_pix),
    .we_weight    (wr & sel_wt),
    .waddr        (offs[IDXW-1:0]),
    .wdata_pixel  (PWDATA),
    .wdata_weight (PWDATA[WW-1:0]),
    .raddr        (raddr),
    .rd_pixel     (rd_pixel),
    .rd_weight    (rd_weight)
  );

  // Per-pixel dot product: unsigned channel times signed weight
  always_comb begin : mac
    logic signed [ACC_WIDTH-1:0] p_x;
    logic signed [ACC_WIDTH-1:0] w_x;
    logic [WP-1:0]               w_c;
    dot = '0;
    p_x = '0;
    w_x = '0;
    w_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_c = rd_weight[c*WP +: WP];
      w_x = {{(ACC_WIDTH-WP){w_c[WP-1]}}, w_c};
      p_x = {{(ACC_WIDTH-CW){1'b0}}, rd_pixel[c*CW +: CW]};
      dot = dot + p_x * w_x;
    end
  end

  // Final score: widen by one bit so bias addition cannot overflow, then clamp
  always_comb begin
    s     = {acc[ACC_WIDTH-1], acc} + {{(SW-AMBA_WORD){bias[AMBA_WORD-1]}}, bias};
    s_max = {{(SW-AMBA_WORD+1){1'b0}}, {(AMBA_WORD-1){1'b1}}};
    s_min = {{(SW-AMBA_WORD+1){1'b1}}, {(AMBA_WORD-1){1'b0}}};
    if (s > s_max)      score_sat = s_max[AMBA_WORD-1:0];
    else if (s < s_min) score_sat = s_min[AMBA_WORD-1:0];
    else                score_sat = s[AMBA_WORD-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ev) state_nxt = S_RUN;
      S_RUN:    if (last)     state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath and status registers. The product is registered before being
  // accumulated, so RUN spends one extra cycle draining the last product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      last     <= 1'b0;
      acc      <= '0;
      prod     <= '0;
      bias     <= '0;
      score    <= '0;
      done     <= 1'b0;
      result   <= 1'b0;
      done_irq <= 1'b0;
    end else begin
      done_irq <= 1'b0;
      if (wr && sel_bias) bias <= PWDATA;
      if (start_ev) begin
        idx    <= '0;
        last   <= 1'b0;
        acc    <= '0;
        prod   <= '0;
        done   <= 1'b0;
        result <= 1'b0;
      end else if (clear_ev) begin
        done   <= 1'b0;
        result <= 1'b0;
      end
      if (state == S_RUN) begin
        acc <= acc + prod;
        if (!last) begin
          prod <= dot;
          if (idx == IDXW'(NUM_PIXELS - 1)) last <= 1'b1;
          else                              idx  <= idx + 1'b1;
        end
      end
      if (state == S_FINISH) begin
        score    <= score_sat;
        result   <= ~s[SW-1];
        done     <= 1'b1;
        done_irq <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_engine.sv
// Scoreboard bench for perceptron_engine (4 pixels, 3 channels, 5-bit weights).
module tb_perceptron_engine;

  localparam int NP  = 4;
  localparam int LAT = NP + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = '0;
  logic [23:0] PWDATA = '0;
  logic [23:0] PRDATA;
  logic        PREADY, PSLVERR, CatRecOut, done_irq;

  perceptron_engine #(
    .AMBA_WORD        (24),
    .AMBA_ADDR_DEPTH  (12),
    .WEIGHT_PRECISION (5),
    .CHANNELS         (3),
    .NUM_PIXELS       (NP),
    .ACC_WIDTH        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .CatRecOut (CatRecOut),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] score;
    logic        res;
    int          start;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] pix_m [NP];
  logic [14:0] wt_m  [NP];
  logic [23:0] bias_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Integer reference: plain sum of products, 32-bit wrap, bias, clamp
  task automatic model(output logic [23:0] sc, output logic res);
    longint a = 0;
    longint p, w, bv, s;
    int     a32;
    for (int i = 0; i < NP; i++)
      for (int c = 0; c < 3; c++) begin
        p = longint'((pix_m[i] >> (8 * c)) & 24'hFF);
        w = longint'((wt_m[i] >> (5 * c)) & 15'h1F);
        if (w >= 16) w -= 32;
        a += p * w;
      end
    a32 = int'(a);
    bv  = longint'(bias_m);
    if (bv >= 64'sh800000) bv -= 64'sh1000000;
    s = longint'(a32) + bv;
    if (s > 64'sd8388607)       sc = 24'h7FFFFF;
    else if (s < -64'sd8388608) sc = 24'h800000;
    else                        sc = s[23:0];
    res = (s >= 0);
  endtask

  // Completion monitor: every done_irq must match the oldest outstanding start
  always @(negedge clk) begin
    if (rst && done_irq) begin
      if (q.size() == 0) begin
        chk("unexpected_done_irq", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("score_on_irq", 32'(dut.score), 32'(e.score));
        chk("catrecout_on_irq", 32'(CatRecOut), 32'(e.res));
        chk("latency", 32'(cyc - e.start), 32'(LAT));
      end
    end
  end

  // All tasks begin and end 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic w, input logic [11:0] a, input logic [23:0] d,
                     output logic [23:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [11:0] a, input logic [23:0] d,
                        input logic exp_err);
    logic [23:0] r;
    logic        e;
    apb(1'b1, a, d, r, e);
    chk({name, "_pslverr"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [23:0] exp_d,
                        input logic exp_err);
    logic [23:0] r;
    logic        e;
    apb(1'b0, a, '0, r, e);
    chk({name, "_prdata"}, 32'(r), 32'(exp_d));
    chk({name, "_pslverr"}, 32'(e), 32'(exp_err));
  endtask

  task automatic wr(input logic [11:0] a, input logic [23:0] d);
    logic [23:0] r;
    logic        e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic load_all(input logic [23:0] p, input logic [14:0] w);
    for (int i = 0; i < NP; i++) begin
      pix_m[i] = p;
      wt_m[i]  = w;
      wr(12'h400 + 12'(i), p);
      wr(12'h800 + 12'(i), {9'd0, w});
    end
  endtask

  task automatic set_bias(input logic [23:0] b);
    bias_m = b;
    wr(12'h002, b);
  endtask

  task automatic do_start(input logic [23:0] ctrl);
    exp_t e;
    model(e.score, e.res);
    wr(12'h000, ctrl);
    e.start = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
    chk("completion_timeout", 32'(q.size()), 32'(0));
    q.delete();
  endtask

  initial begin
    bias_m = '0;
    #23 rst = 1'b1;
    idle(1);

    // Reset state
    chk("reset_done_irq", 32'(done_irq), 32'(0));
    chk("reset_catrecout", 32'(CatRecOut), 32'(0));
    chk("pready", 32'(PREADY), 32'(1));
    rd_chk("reset_status", 12'h001, 24'h0, 1'b0);
    rd_chk("reset_score", 12'h003, 24'h0, 1'b0);
    rd_chk("reset_bias", 12'h002, 24'h0, 1'b0);

    // Basic run: 4 * (1+2+3) - 20 = 4
    load_all(24'h010203, 15'h0421);
    set_bias(24'hFFFFEC);
    rd_chk("pixel0_rb", 12'h400, 24'h010203, 1'b0);
    rd_chk("weight3_rb", 12'h803, 24'h000421, 1'b0);
    rd_chk("ctrl_reads_zero", 12'h000, 24'h0, 1'b0);
    do_start(24'h1);
    wait_done();
    rd_chk("basic_score", 12'h003, 24'h000004, 1'b0);
    rd_chk("basic_status", 12'h001, 24'h6, 1'b0);

    // Negative score: 24 - 25 = -1
    set_bias(24'hFFFFE7);
    do_start(24'h1);
    wait_done();
    rd_chk("neg_score", 12'h003, 24'hFFFFFF, 1'b0);
    rd_chk("neg_status", 12'h001, 24'h2, 1'b0);

    // Positive and negative saturation
    load_all(24'hFFFFFF, 15'h3DEF);
    set_bias(24'h7FFFFF);
    do_start(24'h1);
    wait_done();
    rd_chk("sat_pos_score", 12'h003, 24'h7FFFFF, 1'b0);
    load_all(24'hFFFFFF, 15'h4210);
    set_bias(24'h800000);
    do_start(24'h1);
    wait_done();
    rd_chk("sat_neg_score", 12'h003, 24'h800000, 1'b0);
    rd_chk("sat_neg_status", 12'h001, 24'h2, 1'b0);

    // Illegal writes and a second start while busy
    load_all(24'h010203, 15'h0421);
    set_bias(24'hFFFFEC);
    do_start(24'h1);
    wr_chk("busy_pixel_wr", 12'h400, 24'hABCDEF, 1'b1);
    wr_chk("busy_bias_wr", 12'h002, 24'h000100, 1'b1);
    wr_chk("busy_start_wr", 12'h000, 24'h1, 1'b0);
    wait_done();
    idle(10);
    rd_chk("busy_pixel_kept", 12'h400, 24'h010203, 1'b0);
    rd_chk("busy_bias_kept", 12'h002, 24'hFFFFEC, 1'b0);
    rd_chk("busy_run_score", 12'h003, 24'h000004, 1'b0);

    // Reset two cycles into RUN aborts without an interrupt
    do_start(24'h1);
    idle(2);
    #2 rst = 1'b0;
    #1;
    q.delete();
    chk("abort_done_irq", 32'(done_irq), 32'(0));
    chk("abort_catrecout", 32'(CatRecOut), 32'(0));
    idle(2);
    rst = 1'b1;
    bias_m = '0;
    rd_chk("abort_status", 12'h001, 24'h0, 1'b0);
    rd_chk("abort_score", 12'h003, 24'h0, 1'b0);
    rd_chk("abort_bias", 12'h002, 24'h0, 1'b0);
    idle(12);
    set_bias(24'hFFFFEC);
    do_start(24'h1);
    wait_done();
    rd_chk("restart_score", 12'h003, 24'h000004, 1'b0);

    // Unmapped / out-of-range addresses, then clear in IDLE
    rd_chk("oob_pixel_rd", 12'h404, 24'h0, 1'b1);
    wr_chk("unmapped_wr", 12'h005, 24'h123456, 1'b1);
    rd_chk("unmapped_rd", 12'h005, 24'h0, 1'b1);
    wr(12'h000, 24'h2);
    rd_chk("clear_status", 12'h001, 24'h0, 1'b0);
    chk("clear_catrecout", 32'(CatRecOut), 32'(0));
    rd_chk("clear_score_kept", 12'h003, 24'h000004, 1'b0);

    // Randomized images; start+clear together must behave as start
    for (int r = 0; r < 8; r++) begin
      exp_t e;
      for (int i = 0; i < NP; i++) begin
        pix_m[i] = 24'($urandom);
        wt_m[i]  = 15'($urandom);
        wr(12'h400 + 12'(i), pix_m[i]);
        wr(12'h800 + 12'(i), {9'd0, wt_m[i]});
      end
      if (r % 3 == 0) set_bias(24'($urandom));
      else            set_bias(24'($urandom_range(0, 4000)) - 24'd2000);
      model(e.score, e.res);
      do_start((r % 2 == 1) ? 24'h3 : 24'h1);
      wait_done();
      rd_chk("rand_score", 12'h003, e.score, 1'b0);
      rd_chk("rand_status", 12'h001, {21'd0, e.res, 2'b10}, 1'b0);
    end

    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_engine.md
PERCEPTRON_ENGINE -- requirements
Module: perceptron_engine

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 24, APB data width and pixel word (CHANNELS packed unsigned channels).
REQ-002 SHALL have parameter AMBA_ADDR_DEPTH, default 12, APB word-address width.
REQ-003 SHALL have parameter WEIGHT_PRECISION, default 5, signed two's-complement weight width per channel.
REQ-004 SHALL have parameter CHANNELS, default 3, channels per pixel; channel width CW = AMBA_WORD/CHANNELS; CHANNELS*WEIGHT_PRECISION <= AMBA_WORD.
REQ-005 SHALL have parameter NUM_PIXELS, default 1024, pixels per image; NUM_PIXELS <= 1024.
REQ-006 SHALL have parameter ACC_WIDTH, default 32, signed accumulator width.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: PSEL in 1; PENABLE in 1; PWRITE in 1; PADDR in AMBA_ADDR_DEPTH word address; PWDATA in AMBA_WORD.
REQ-009 SHALL have ports: PRDATA out AMBA_WORD; PREADY out 1, tied 1; PSLVERR out 1, valid in access phase.
REQ-010 SHALL have ports: CatRecOut out 1, registered classification; done_irq out 1, one-cycle pulse on completion.

Function
REQ-011 Address map SHALL be: 0x000 CTRL (W: bit0 start, bit1 clear; reads 0); 0x001 STATUS (RO: bit0 busy, bit1 done, bit2 result); 0x002 BIAS (RW, signed AMBA_WORD); 0x003 SCORE (RO); 0x400+i PIXEL[i] (RW); 0x800+i WEIGHT[i] (RW, channel c at bits [c*WP +: WP]).
REQ-012 APB transfer SHALL take effect at the rising edge with PSEL=PENABLE=1; PRDATA combinational from PADDR in access phase, 0 when not reading.
REQ-013 Unmapped address, or i >= NUM_PIXELS, SHALL give PSLVERR=1, read 0, write ignored.
REQ-014 While busy, writes to BIAS/PIXEL/WEIGHT and reads of PIXEL/WEIGHT SHALL be ignored/return 0 with PSLVERR=1; STATUS, SCORE, CTRL access SHALL be legal.
REQ-015 FSM SHALL have states IDLE, RUN, FINISH; reset state IDLE.
REQ-016 IDLE->RUN on write CTRL.start=1: index and accumulator cleared, done and result cleared, busy=1 from next edge.
REQ-017 RUN SHALL process one pixel per cycle: acc += sum over c of $unsigned(pixel[c]) * $signed(weight[c]), products sign-extended to ACC_WIDTH; RUN->FINISH after pixel NUM_PIXELS-1.
REQ-018 FINISH SHALL compute s = acc + sign-extended BIAS, set SCORE = s saturated to signed AMBA_WORD range, result = (s >= 0), CatRecOut = result, done=1, busy=0, pulse done_irq, go IDLE.
REQ-019 Latency SHALL be fixed: done=1 and CatRecOut valid exactly NUM_PIXELS+2 edges after the start write edge.
REQ-020 start while busy SHALL be ignored (no PSLVERR); clear while busy SHALL be ignored.
REQ-021 CTRL clear in IDLE SHALL zero done, result, CatRecOut; SCORE retained; start=1 and clear=1 together SHALL act as start.
REQ-022 Accumulator SHALL wrap modulo 2^ACC_WIDTH (no internal saturation); saturation only at SCORE.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, busy=0, done=0, result=0, CatRecOut=0, done_irq=0, SCORE=0, BIAS=0, accumulator=0, index=0.
REQ-024 Reset mid-RUN SHALL abort with no done_irq; pixel/weight storage SHALL NOT be reset (contents undefined after power-up).

Structure
REQ-025 Address-map constants, CTRL/STATUS bit indices and FSM state encoding SHALL live in shared package perceptron_pkg.
REQ-026 Pixel and weight storage SHALL be one sub-module pixel_weight_ram (dual array, one APB write port, one combinational read port muxed APB/engine by busy).

Verification (NUM_PIXELS=4, CHANNELS=3, WEIGHT_PRECISION=5)
REQ-027 Pixels all 0x010203, weights all +1 per channel, BIAS=-20, start -> done after 6 edges, SCORE=4, CatRecOut=1, one done_irq pulse.
REQ-028 Same with BIAS=-25 -> SCORE=0xFFFFFF, CatRecOut=0, STATUS=0x2.
REQ-029 Pixels 0xFFFFFF, weights +15, BIAS=0x7FFFFF -> SCORE=0x7FFFFF (saturated), CatRecOut=1; weights -16, BIAS=0x800000 -> SCORE=0x800000, CatRecOut=0.
REQ-030 Write PIXEL[0] and BIAS during RUN -> PSLVERR=1, values unchanged, result identical to REQ-027; start during RUN ignored.
REQ-031 rst low 2 cycles into RUN -> STATUS=0, SCORE=0, no done_irq; restart with BIAS rewritten -> REQ-027 result.
REQ-032 Access 0x404 and 0x005 -> PSLVERR=1, PRDATA=0; clear in IDLE after REQ-027 -> STATUS=0, CatRecOut=0, SCORE=4.
